// File: rtl/my_mul_pkg.sv
// Shared types and default widths for the my_mul sequential signed multiplier.
package my_mul_pkg;

    localparam int DEF_A_BITS = 10;
    localparam int DEF_B_BITS = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/my_mul_abs.sv
// Two's complement to unsigned magnitude; the most negative input maps to 2^(W-1).
module my_mul_abs #(
    parameter int W = 10
) (
    input  logic [W-1:0] val_i,
    output logic [W-1:0] mag_o
);

    assign mag_o = val_i[W-1] ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/my_mul.sv
// Radix-2 shift-add signed multiplier, one multiplier bit per cycle, LSB first.
// Optional macro MY_MUL_ADDEND_EN adds port r: product = sign * (|a|*|b| + r).
module my_mul
    import my_mul_pkg::*;
#(
    parameter int A_BITS = DEF_A_BITS,
    parameter int B_BITS = DEF_B_BITS,
    parameter int P_BITS = A_BITS + B_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [A_BITS-1:0] a,
    input  logic [B_BITS-1:0] b,
`ifdef MY_MUL_ADDEND_EN
    input  logic [A_BITS-1:0] r,
`endif
    output logic              busy,
    output logic              done,
    output logic [P_BITS-1:0] product
);

    localparam int CNT_W = $clog2(B_BITS);

    mul_state_e        state_q, state_d;
    logic [P_BITS-1:0] mcand_q, mcand_d;
    logic [B_BITS-1:0] mplier_q, mplier_d;
    logic [P_BITS-1:0] acc_q, acc_d;
    logic [A_BITS-1:0] addend_q, addend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [P_BITS-1:0] product_q, product_d;
    logic              done_q, done_d;

    logic [A_BITS-1:0] a_mag_s;
    logic [B_BITS-1:0] b_mag_s;
    logic              accept_s;
    logic [P_BITS-1:0] acc_sum_s;
    logic [P_BITS-1:0] final_s;

    my_mul_abs #(.W(A_BITS)) u_abs_a (.val_i(a), .mag_o(a_mag_s));
    my_mul_abs #(.W(B_BITS)) u_abs_b (.val_i(b), .mag_o(b_mag_s));

    // Next-state logic for FSM, counter and shift-add datapath
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        addend_d  = addend_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;
        done_d    = 1'b0;
        accept_s  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {P_BITS{1'b0}});
        final_s   = acc_sum_s + {{(P_BITS-A_BITS){1'b0}}, addend_q};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    mcand_d  = {{(P_BITS-A_BITS){1'b0}}, a_mag_s};
                    mplier_d = b_mag_s;
                    sign_d   = a[A_BITS-1] ^ b[B_BITS-1];
                    acc_d    = {P_BITS{1'b0}};
                    cnt_d    = CNT_W'(B_BITS - 1);
`ifdef MY_MUL_ADDEND_EN
                    addend_d = r;
`else
                    addend_d = {A_BITS{1'b0}};
`endif
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    // Negation in P_BITS keeps a zero magnitude at zero.
                    product_d = sign_q ? (~final_s + {{(P_BITS-1){1'b0}}, 1'b1}) : final_s;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d     = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= {P_BITS{1'b0}};
            mplier_q  <= {B_BITS{1'b0}};
            acc_q     <= {P_BITS{1'b0}};
            addend_q  <= {A_BITS{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            sign_q    <= 1'b0;
            product_q <= {P_BITS{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            addend_q  <= addend_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule
